// File: rtl/stack_pkg.sv
// Shared sizing, FSM state encoding and {push,pop} opcode encoding for the LIFO controller.
package stack_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_t;

endpackage

// File: rtl/stack_row_decoder.sv
// Index-to-one-hot decoder with enable; drives the per-row clock enables of the matrix.
module stack_row_decoder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] idx,
    output logic [DEPTH-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stack_lifo_ctrl.sv
// LIFO sequencing controller: stack pointer, EMPTY/PARTIAL/FULL FSM, sticky error flags
// and the one-hot row write-enables for the register-matrix datapath.
module stack_lifo_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH  = stack_pkg::DEPTH,
    parameter int unsigned ADDR_W = stack_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    output logic [DEPTH-1:0]  row_we,
    output logic [ADDR_W-1:0] tos_addr,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned      CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   tos_q, tos_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                we_en;
    logic [ADDR_W-1:0]   we_idx;
    op_t                 op;

    assign op = op_t'({push, pop});

    // State register; every status output moves on the same edge as the pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            tos_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tos_q   <= tos_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Next-state: pointer update and flag setting; clear overrides any request.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        tos_d   = tos_q;
        empty_d = empty_q;
        full_d  = full_q;

        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (state_q != ST_FULL) count_d = count_q + CNT_W'(1);
                    else                    ovf_d   = 1'b1;
                end
                OP_POP: begin
                    if (state_q != ST_EMPTY) count_d = count_q - CNT_W'(1);
                    else                     udf_d   = 1'b1;
                end
                OP_REPLACE: begin
                    if (state_q == ST_EMPTY) begin
                        count_d = CNT_W'(1);
                        udf_d   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        if (count_d == '0)           state_d = ST_EMPTY;
        else if (count_d == CNT_FULL) state_d = ST_FULL;
        else                          state_d = ST_PARTIAL;

        tos_d   = (count_d == '0) ? '0 : ADDR_W'(count_d - CNT_W'(1));
        empty_d = (state_d == ST_EMPTY);
        full_d  = (state_d == ST_FULL);
    end

    // Row write-enable: push writes row count, replace writes row count-1 (row 0 when empty).
    always_comb begin
        we_en  = 1'b0;
        we_idx = ADDR_W'(count_q);
        if (!reset && !clear) begin
            case (op)
                OP_PUSH: begin
                    we_en = (state_q != ST_FULL);
                end
                OP_REPLACE: begin
                    we_en = 1'b1;
                    if (state_q != ST_EMPTY) we_idx = ADDR_W'(count_q - CNT_W'(1));
                end
                default: begin
                end
            endcase
        end
    end

    stack_row_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .en     (we_en),
        .idx    (we_idx),
        .onehot (row_we)
    );

    assign tos_addr  = tos_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_stack_lifo_ctrl.sv
// Self-checking bench for stack_lifo_ctrl with a behavioural row matrix and a queue-based stack model.
module tb_stack_lifo_ctrl;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        push;
    logic        pop;
    logic [7:0]  data_in;
    logic [15:0] row_we;
    logic [3:0]  tos_addr;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [16];
    logic [7:0]  mq [$];
    bit          m_ovf;
    bit          m_udf;
    logic [15:0] obs_we;
    logic [15:0] exp_we;
    logic [7:0]  obs_rd_pre;
    logic [7:0]  exp_rd_pre;
    bit          pre_valid;

    stack_lifo_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .row_we    (row_we),
        .tos_addr  (tos_addr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Storage matrix: rows capture data_in on their clock enable.
    always @(posedge clock) begin
        for (int i = 0; i < 16; i++) begin
            if (row_we[i]) mem[i] <= data_in;
        end
    end

    function automatic logic [4:0] exp_count();
        return 5'(mq.size());
    endfunction

    function automatic logic [3:0] exp_tos();
        return (mq.size() == 0) ? 4'd0 : 4'(mq.size() - 1);
    endfunction

    // One clock of stimulus, starting and ending at a falling edge; advances the model.
    task automatic cycle(input bit p, input bit q, input bit c, input logic [7:0] d);
        push    = p;
        pop     = q;
        clear   = c;
        data_in = d;
        #1;
        obs_we     = row_we;
        pre_valid  = (mq.size() != 0);
        obs_rd_pre = mem[tos_addr];
        exp_rd_pre = pre_valid ? mq[mq.size()-1] : 8'h00;
        exp_we     = '0;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (p && !q) begin
            if (mq.size() < 16) begin
                exp_we = 16'(1) << mq.size();
                mq.push_back(d);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (!p && q) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else               m_udf = 1'b1;
        end else if (p && q) begin
            if (mq.size() > 0) begin
                exp_we = 16'(1) << (mq.size() - 1);
                mq[mq.size()-1] = d;
            end else begin
                exp_we = 16'h0001;
                mq.push_back(d);
                m_udf = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        push  = 1'b1;
        pop   = 1'b0;
        clear = 1'b0;
        data_in = 8'h00;
        repeat (2) @(negedge clock);
        checks++;
        if (row_we !== 16'h0000) begin
            errors++; $display("FAIL reset_row_we: got %h want 0000", row_we);
        end
        checks++;
        if ({count, tos_addr, empty, full, overflow, underflow} !== {5'd0, 4'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_state: count=%0d tos=%0d e=%b f=%b o=%b u=%b want 0 0 1 0 0 0",
                     count, tos_addr, empty, full, overflow, underflow);
        end
        push  = 1'b0;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'(i + 1));
            checks++;
            if (obs_we !== (16'(1) << i)) begin
                errors++; $display("FAIL fill_row_we[%0d]: got %h want %h", i, obs_we, 16'(1) << i);
            end
        end
        checks++;
        if ({count, full, empty, tos_addr} !== {5'd16, 1'b1, 1'b0, 4'd15}) begin
            errors++;
            $display("FAIL fill_final: count=%0d full=%b empty=%b tos=%0d want 16 1 0 15",
                     count, full, empty, tos_addr);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'hEE);
        checks++;
        if (obs_we !== 16'h0000 || count !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_push: row_we=%h count=%0d ovf=%b want 0000 16 1", obs_we, count, overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tos_addr !== 4'(15 - i)) begin
                errors++; $display("FAIL drain_tos[%0d]: got %0d want %0d", i, tos_addr, 15 - i);
            end
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            checks++;
            if (obs_rd_pre !== 8'(16 - i)) begin
                errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, obs_rd_pre, 8'(16 - i));
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL drain_final: empty=%b count=%0d want 1 0", empty, count);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (underflow !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL underflow_pop: udf=%b count=%0d want 1 0", underflow, count);
        end
    endtask

    task automatic test_replace();
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 1'b0, 8'hAA);
        checks++;
        if (obs_we !== 16'h0010 || count !== 5'd5 || tos_addr !== 4'd4) begin
            errors++;
            $display("FAIL replace_top: row_we=%h count=%0d tos=%0d want 0010 5 4", obs_we, count, tos_addr);
        end
        checks++;
        if (mem[tos_addr] !== 8'hAA || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL replace_data: top=%h ovf=%b udf=%b want aa 0 0", mem[tos_addr], overflow, underflow);
        end
    endtask

    task automatic test_empty_replace();
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 8'h3C);
        checks++;
        if (obs_we !== 16'h0001 || count !== 5'd1 || underflow !== 1'b1 || mem[tos_addr] !== 8'h3C) begin
            errors++;
            $display("FAIL empty_replace: row_we=%h count=%0d udf=%b top=%h want 0001 1 1 3c",
                     obs_we, count, underflow, mem[tos_addr]);
        end
    endtask

    task automatic test_clear();
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (count !== 5'd7 || overflow !== 1'b1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup: count=%0d ovf=%b udf=%b want 7 1 1", count, overflow, underflow);
        end
        cycle(1'b1, 1'b0, 1'b1, 8'h55);
        checks++;
        if (obs_we !== 16'h0000 || count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_push: row_we=%h count=%0d ovf=%b udf=%b empty=%b want 0000 0 0 0 1",
                     obs_we, count, overflow, underflow, empty);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] snap [16];
        int         bad;
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
        push    = 1'b1;
        data_in = 8'hC3;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (row_we !== 16'h0000 || count !== 5'd0 || tos_addr !== 4'd0 || empty !== 1'b1 ||
            full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: row_we=%h count=%0d tos=%0d e=%b f=%b o=%b u=%b want 0000 0 0 1 0 0 0",
                     row_we, count, tos_addr, empty, full, overflow, underflow);
        end
        for (int i = 0; i < 16; i++) snap[i] = mem[i];
        @(posedge clock);
        #1;
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== snap[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL async_reset_write: %0d rows changed, want 0", bad);
        end
        @(negedge clock);
        reset = 1'b0;
        push  = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clock);
        cycle(1'b1, 1'b0, 1'b0, 8'h5A);
        checks++;
        if (obs_we !== 16'h0001 || mem[0] !== 8'h5A) begin
            errors++; $display("FAIL post_reset_push: row_we=%h row0=%h want 0001 5a", obs_we, mem[0]);
        end
    endtask

    task automatic test_random();
        int r;
        bit p, q, c;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            c = (r < 3);
            p = (r >= 3 && r < 55) || (r >= 80 && r < 95);
            q = (r >= 55 && r < 95);
            cycle(p, q, c, 8'($urandom));
            checks++;
            if (obs_we !== exp_we) begin
                errors++; $display("FAIL rnd_row_we[%0d]: got %h want %h", n, obs_we, exp_we);
            end
            checks++;
            if (count !== exp_count() || tos_addr !== exp_tos() ||
                empty !== (mq.size() == 0) || full !== (mq.size() == 16)) begin
                errors++;
                $display("FAIL rnd_status[%0d]: count=%0d tos=%0d e=%b f=%b want %0d %0d %b %b", n,
                         count, tos_addr, empty, full, exp_count(), exp_tos(), mq.size() == 0, mq.size() == 16);
            end
            checks++;
            if (overflow !== m_ovf || underflow !== m_udf) begin
                errors++;
                $display("FAIL rnd_flags[%0d]: ovf=%b udf=%b want %b %b", n, overflow, underflow, m_ovf, m_udf);
            end
            if (pre_valid) begin
                checks++;
                if (obs_rd_pre !== exp_rd_pre) begin
                    errors++; $display("FAIL rnd_top[%0d]: got %h want %h", n, obs_rd_pre, exp_rd_pre);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_replace();
        test_empty_replace();
        test_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
